// File: rtl/lsu_pkg.sv
// Shared types, RV32I funct3 codes and lane helpers for the load/store bus controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Loads accept all five width codes; stores only the signed-width codes.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'd0);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte-lane enables; width comes from funct3[1:0] so BU/HU share the B/H lanes.
    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] sel;
        sel = 4'hF;
        case (f3[1:0])
            2'd0:    sel = 4'b0001 << off;
            2'd1:    sel = 4'b0011 << off;
            default: sel = 4'hF;
        endcase
        return sel;
    endfunction

    // Replicate narrow store data across all lanes so sel alone picks the target bytes.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (f3[1:0])
            2'd0:    d = {4{wdata[7:0]}};
            2'd1:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Move the addressed lane down to bit 0, then sign- or zero-extend by funct3.
    function automatic logic [31:0] lane_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] d;
        sh = word >> {off, 3'b000};
        d  = sh;
        case (f3)
            F3_B:    d = {{24{sh[7]}}, sh[7:0]};
            F3_H:    d = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   d = {24'd0, sh[7:0]};
            F3_HU:   d = {16'd0, sh[15:0]};
            default: d = sh;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data alignment: selects the addressed lane of the bus word and extends it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data
);

    // Pure combinational lane select and extension.
    always_comb begin
        load_data = lane_extend(funct3, bus_rdata, offset);
    end

endmodule

// File: rtl/lsu_bus_controller.sv
// Load/store bus controller: sequences memory-stage accesses onto a single-port,
// wait-stated data bus, stalling the pipeline until the bus acknowledges.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus cycle with access_err
// after TIMEOUT_CYCLES cycles without bus_ack; otherwise REQ waits indefinitely.
//
// Handshake: req_valid is sampled only in IDLE; while stall is 1 the memory stage
// holds. rsp_valid and access_err are one-cycle pulses. bus_stb stays high with
// stable addr/sel/we/wdata until the cycle in which bus_ack is 1 (possibly the
// first stb cycle); bus_rdata is taken in that same cycle.
module lsu_bus_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  flush,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  access_err,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_sel,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata,
    output lsu_state_e            state_dbg
);

    lsu_state_e            state;
    logic                  drop_q;
    logic                  err_q;
    logic                  stb_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [31:0]           rdata_q;
    logic [31:0]           load_data;
    logic                  req_ok;
    logic                  accept;
    logic                  reject;
    logic                  to_hit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // The last REQ cycle allowed before the bus cycle is abandoned.
    always_comb begin
        to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end
`else
    // Without the timeout feature REQ only ever leaves on bus_ack.
    always_comb begin
        to_hit = 1'b0;
    end
`endif

    // Classify the incoming request while idle.
    always_comb begin
        req_ok = f3_legal(req_funct3, req_is_store) && !f3_misaligned(req_funct3, req_addr[1:0]);
        accept = (state == IDLE) && req_valid && !flush && req_ok;
        reject = (state == IDLE) && req_valid && !flush && !req_ok;
    end

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (off_q),
        .bus_rdata (bus_rdata),
        .load_data (load_data)
    );

    // Control FSM: latches the request, runs the bus cycle, then reports once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= REQ;
                        stb_q   <= 1'b1;
                        we_q    <= req_is_store;
                        addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        sel_q   <= lane_sel(req_funct3, req_addr[1:0]);
                        wdata_q <= lane_wdata(req_funct3, req_wdata);
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        drop_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end else if (reject) begin
                        err_q <= 1'b1;
                    end
                end
                REQ: begin
                    // A flush cannot abort a started bus cycle; only its response is dropped.
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus_ack) begin
                        state   <= DONE;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        rdata_q <= we_q ? 32'd0 : load_data;
                    end else if (to_hit) begin
                        state  <= DONE;
                        stb_q  <= 1'b0;
                        we_q   <= 1'b0;
                        drop_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        to_cnt <= to_cnt + TO_W'(1);
`endif
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    drop_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output mapping; stall covers the accept cycle and every REQ cycle.
    always_comb begin
        stall      = accept || (state == REQ);
        rsp_valid  = (state == DONE) && !drop_q && !flush;
        rsp_rdata  = rdata_q;
        access_err = err_q;
        bus_stb    = stb_q;
        bus_we     = we_q;
        bus_addr   = addr_q;
        bus_sel    = sel_q;
        bus_wdata  = wdata_q;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Bench for lsu_bus_controller: driver tasks issue requests, a bus responder
// plays the memory, and a monitor pops expected responses from a queue.
module tb_lsu_bus_controller;
    import lsu_pkg::*;

    localparam int AW = 32;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_is_store;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          flush;
    logic          stall;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          access_err;
    logic          bus_stb;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_sel;
    logic [31:0]   bus_wdata;
    logic          bus_ack;
    logic [31:0]   bus_rdata;
    lsu_state_e    state_dbg;

    lsu_bus_controller #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .flush        (flush),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .access_err   (access_err),
        .bus_stb      (bus_stb),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int compared   = 0;
    int mismatched = 0;

    // {is_err, rdata}
    logic [32:0] exp_q[$];

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } bus_exp_t;
    bus_exp_t bus_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_ok(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return legal && ((addr % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] addr);
        int mask;
        mask = (1 << m_size(f3)) - 1;
        return 4'(mask << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] b;
        logic [31:0] h;
        b = {24'd0, wd[7:0]};
        h = {16'd0, wd[15:0]};
        if (m_size(f3) == 1) return b * 32'h0101_0101;
        if (m_size(f3) == 2) return h * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [63:0] v;
        logic [63:0] mask;
        int          bits;
        bits = 8 * m_size(f3);
        v    = {32'd0, rd} >> (8 * (addr % 4));
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if (!f3[2] && bits < 32 && (((v >> (bits - 1)) & 64'd1) == 64'd1))
            v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- bus responder ----------------
    initial begin : responder
        bus_exp_t e;
        bit       in_cycle;
        int       waits_left;
        in_cycle   = 0;
        waits_left = 0;
        e          = '0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst || !bus_stb) begin
                in_cycle = 0;
                bus_ack  = 1'b0;
            end else begin
                if (!in_cycle) begin
                    if (bus_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_stb: bus_stb=1 addr=%h with no cycle expected", bus_addr);
                        e = '0;
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_addr", bus_addr, e.addr);
                        check("bus_sel", {28'd0, bus_sel}, {28'd0, e.sel});
                        check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                        if (e.we) check("bus_wdata", bus_wdata, e.wdata);
                    end
                    in_cycle   = 1;
                    waits_left = e.waits;
                end
                if (waits_left == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = e.rdata;
                    in_cycle  = 0;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                    waits_left--;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (rsp_valid || access_err) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b access_err=%b with nothing expected",
                             rsp_valid, access_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, !e[32]});
                    check("access_err", {31'd0, access_err}, {31'd0, e[32]});
                    if (!e[32]) check("rsp_rdata", rsp_rdata, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // mode: 0 normal, 1 flush in 2nd REQ cycle, 2 flush in DONE, 3 expect timeout
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits,
                          input int mode);
        bit       ok;
        bus_exp_t be;
        int       k;
        bit       done;
        int       req_cycles;
        ok = m_ok(st, f3, addr);
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        if (ok) begin
            be.addr  = addr & 32'hFFFF_FFFC;
            be.sel   = m_sel(f3, addr);
            be.we    = st;
            be.wdata = m_wdata(f3, wd);
            be.rdata = rd;
            be.waits = waits;
            bus_q.push_back(be);
            if (mode == 0) exp_q.push_back({1'b0, st ? 32'd0 : m_load(f3, addr, rd)});
            if (mode == 3) exp_q.push_back({1'b1, 32'd0});
        end else begin
            exp_q.push_back({1'b1, 32'd0});
        end
        #1;
        check("stall_accept", {31'd0, stall}, {31'd0, ok});
        @(posedge clk);
        #1;
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        // Request inputs are ignored outside IDLE; keep them noisy meanwhile.
        req_valid    = 1'($urandom_range(0, 1));
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        k    = 0;
        done = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            if (stall) begin
                k++;
                flush = (mode == 1 && k == 2);
            end else begin
                done  = 1;
                flush = (mode == 2);
            end
        end
        req_cycles = (mode == 3) ? TO : waits + 1;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL stall_timeout: stall still 1 after %0d cycles", k);
        end else begin
            check("stall_cycles", 32'(1 + k), 32'(1 + req_cycles));
        end
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
    endtask

    // Assert reset while the bus cycle is waiting; stb must fall at the next edge.
    task automatic reset_mid_req();
        bus_exp_t be;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = F3_W;
        req_addr     = 32'h0000_0400;
        req_wdata    = 32'd0;
        be.addr  = 32'h0000_0400;
        be.sel   = 4'hF;
        be.we    = 1'b0;
        be.wdata = 32'd0;
        be.rdata = 32'd0;
        be.waits = 1000;
        bus_q.push_back(be);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stb_before_rst", {31'd0, bus_stb}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("stb_after_rst", {31'd0, bus_stb}, 32'd0);
        check("stall_after_rst", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          w;
        int          r;
        int          mode;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = '0;
        req_wdata    = 32'd0;
        flush        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_access_err", {31'd0, access_err}, 32'd0);
        check("rst_bus_stb", {31'd0, bus_stb}, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;

        // directed cases
        do_req(1'b0, F3_W,  32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
        do_req(1'b0, F3_B,  32'h0000_0103, 32'd0, 32'h80FF_0000, 1, 0);
        do_req(1'b0, F3_BU, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0);
        do_req(1'b1, F3_H,  32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555, 3, 0);
        do_req(1'b0, F3_W,  32'h0000_0101, 32'd0, 32'd0, 0, 0);
        do_req(1'b0, 3'd3,  32'h0000_0100, 32'd0, 32'd0, 0, 0);
        do_req(1'b1, F3_BU, 32'h0000_0100, 32'd0, 32'd0, 0, 0);
        do_req(1'b0, F3_HU, 32'h0000_0102, 32'd0, 32'h8001_7FFF, 2, 0);
        do_req(1'b0, F3_H,  32'h0000_0102, 32'd0, 32'h8001_7FFF, 0, 0);
        do_req(1'b0, F3_W,  32'h0000_0200, 32'd0, 32'h1111_2222, 3, 1);
        do_req(1'b0, F3_W,  32'h0000_0204, 32'd0, 32'h3333_4444, 0, 0);
        do_req(1'b0, F3_W,  32'h0000_0208, 32'd0, 32'h5555_6666, 1, 2);
        do_req(1'b1, F3_B,  32'h0000_0209, 32'h0000_00A5, 32'd0, 0, 0);
`ifdef LSU_TIMEOUT_EN
        do_req(1'b0, F3_W,  32'h0000_0300, 32'd0, 32'd0, 1000, 3);
        do_req(1'b0, F3_W,  32'h0000_0304, 32'd0, 32'hCAFE_F00D, 0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            w    = $urandom_range(0, 3);
            r    = $urandom_range(0, 9);
            mode = 0;
            if (r == 0 && w >= 1) mode = 1;
            if (r == 1) mode = 2;
            do_req(st, f3, a, $urandom, $urandom, w, mode);
        end

        reset_mid_req();
        do_req(1'b0, F3_H, 32'h0000_0500, 32'd0, 32'h0000_F00F, 0, 0);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
